ac97_capture: RTL and testbench
===============================

# ac97_capture

AC97 record-path deserializer: reconstructs AC-link frames from the codec's serial input stream and extracts the 20-bit PCM left/right capture samples from slots 3 and 4. Each valid stereo pair is pushed, left then right, into the 20-bit-wide write port of an async FIFO that the CPU drains. It sits in the bit_clk domain beside the AC97 playback controller, which generates `sync`.

## Interface
- `OVF_WIDTH`, 8: width of the saturating overflow counter.
- `clk`  in  1  AC97 bit clock (buffered bit_clk); the only clock.
- `rst_b`  in  1  synchronous, active-low reset.
- `sdata_in`  in  1  codec serial data, already registered (sampled on negedge bit_clk).
- `sync`  in  1  registered AC-link SYNC, as driven to the codec.
- `capture_en`  in  1  when low, frames are still tracked but no FIFO writes occur.
- `fifo_full`  in  1  async FIFO full flag (write side).
- `fifo_wr_en`  out  1  FIFO write strobe; combinational from state and `fifo_full`.
- `fifo_din`  out  20  sample to write; registered.
- `locked`  out  1  high once a SYNC rising edge has been seen.
- `codec_ready`  out  1  tag bit 15 of the most recent frame.
- `overflow_count`  out  OVF_WIDTH  stereo pairs dropped due to FIFO full; saturates at all-ones.
- `resync_count`  out  8  SYNC rising edges arriving at bit index ≠ 0; saturates at 255.

## Operation
- Reset (`rst_b`=0 at an edge): every output 0. Bit counter = 0, state IDLE, `prev_sync` = 1, so a SYNC edge requires an observed low.
- SYNC edge: `sync`=1 and `prev_sync`=0 at an edge. That edge's `sdata_in` is frame bit 0, and the bit counter is forced to 1 afterward. `locked` goes to 1.
- If the counter was not about to wrap to 0 when the SYNC edge arrived, `resync_count` increments. This happens when the edge arrives while `locked`=1.
- Free running: while `locked`, the counter is 8 bits, 0..255, and wraps. Data shifts in MSB first.
- Frame layout:
  - Bits 0–15: tag. Tag bit 15 = codec ready; 12 = slot 3 valid; 11 = slot 4 valid.
  - Bits 56–75: slot 3 (left).
  - Bits 76–95: slot 4 (right).
- `codec_ready` updates at the edge that samples bit 15.
- Left holding register loads at bit 75; right holding register loads at bit 95.
- Capture condition, evaluated at bit 95: `capture_en` & tag15 & tag12 & tag11. When true, the pair is pending.
- State machine IDLE → WR_L → WR_R → IDLE:
  - IDLE: a pending pair moves to WR_L and `fifo_din` ← left.
  - WR_L: `fifo_wr_en` = ~`fifo_full`.
    - Not full: left is written at the next edge, `fifo_din` ← right, go to WR_R.
    - Full: drop the pair, increment `overflow_count`, go to IDLE. Right is never written without its left.
  - WR_R: `fifo_wr_en` = ~`fifo_full`. Wait while full; on write go to IDLE.
    - If a new pair becomes pending while still in WR_R, the new pair is dropped and `overflow_count` increments.
    - The held right sample stays until written.
- `capture_en` falling mid-write does not abort WR_L or WR_R.
- Reset mid-frame or mid-write: immediate return to reset state, pending data discarded, no partial write.

## Timing
- Let edge n be the SYNC edge, carrying bit 0. Bit k is sampled at edge n+k.
- Write timing with FIFO not full:
  - Left: `fifo_wr_en` is high in the cycle after edge n+95, and the FIFO accepts left at edge n+96.
  - Right: accepted at edge n+97.
  - Latency from the last right bit to the right write is 2 edges.
- `fifo_wr_en` is never high for more than one edge per sample. It is never high while `fifo_full`=1.
- A frame is 256 edges, so WR_R may stall up to 255 edges before the next pair collides.
- Counters saturate; there is no wrap.

## Test plan
- Reset: hold `rst_b`=0 with random `sync`/`sdata_in`. All outputs stay 0, and the first edge after reset gives no false SYNC if `sync` was already high.
- Nominal frame:
  - Stimulus: SYNC edge, tag 0x9800, left 0xABCDE, right 0x12345.
  - Required: writes 0xABCDE at n+96 and 0x12345 at n+97; `codec_ready`=1, counters 0.
- Invalid tags:
  - Tag 0x9000 (slot 4 invalid): no writes.
  - Tag 0x1800 (codec not ready): no writes.
  - `capture_en`=0 with tag 0x9800: no writes, `locked`=1.
- Full at left:
  - `fifo_full`=1 during WR_L: no writes, `overflow_count`=1.
  - 300 consecutive full frames: saturates at 255.
- Full at right:
  - Left written, then `fifo_full`=1 for 10 edges: right written exactly once at the first edge where full=0, `overflow_count`=0.
  - Full held through the next bit 95: that frame's pair is dropped, `overflow_count`=1, and the old right is then written.
- Resync: SYNC edge injected at bit 100. `resync_count`=1 and the counter realigns. The following frame at a 256-edge spacing captures correctly.

Source files
------------

// File: rtl/ac97_capture.sv
// AC97 record-path deserializer: tracks AC-link frames on bit_clk and pushes
// valid slot 3/4 PCM pairs (left then right) into an async FIFO write port.
module ac97_capture #(
  parameter int OVF_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 sdata_in,
  input  logic                 sync,
  input  logic                 capture_en,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [19:0]          fifo_din,
  output logic                 locked,
  output logic                 codec_ready,
  output logic [OVF_WIDTH-1:0] overflow_count,
  output logic [7:0]           resync_count,
  output logic [1:0]           dbg_state
);

  // FIFO handshake: a sample is transferred at a rising clk edge where
  // fifo_wr_en=1; fifo_wr_en is never raised while fifo_full=1, and fifo_din
  // is stable for the whole cycle in which fifo_wr_en is high.
  typedef enum logic [1:0] {IDLE = 2'd0, WR_L = 2'd1, WR_R = 2'd2} state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_prev_sync;
  logic                   r_locked;
  logic [7:0]             r_bit_cnt;
  logic [19:0]            r_shift;
  logic                   r_tag_ok;
  logic                   r_codec_ready;
  logic [19:0]            r_left;
  logic [19:0]            r_right;
  logic [19:0]            r_din;
  logic [OVF_WIDTH-1:0]   r_ovf;
  logic [7:0]             r_resync;

  logic                   w_sync_edge;
  logic                   w_bit_valid;
  logic [7:0]             w_bit_idx;
  logic [19:0]            w_word;
  logic                   w_pending;
  logic                   w_ovf_inc;

  assign w_sync_edge = sync & ~r_prev_sync;
  assign w_bit_valid = w_sync_edge | r_locked;
  assign w_bit_idx   = w_sync_edge ? 8'd0 : r_bit_cnt;
  // Current sample appended to the history: the complete field ending at this bit.
  assign w_word      = {r_shift[18:0], sdata_in};
  assign w_pending   = w_bit_valid && (w_bit_idx == 8'd95) && capture_en && r_tag_ok;
  assign w_ovf_inc   = ((r_state == WR_L) && fifo_full) || ((r_state == WR_R) && w_pending);

  // Frame tracking and sample capture
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_prev_sync   <= 1'b1;
      r_locked      <= 1'b0;
      r_bit_cnt     <= 8'd0;
      r_shift       <= 20'd0;
      r_tag_ok      <= 1'b0;
      r_codec_ready <= 1'b0;
      r_left        <= 20'd0;
      r_right       <= 20'd0;
      r_resync      <= 8'd0;
    end else begin
      r_prev_sync <= sync;
      r_shift     <= w_word;
      if (w_sync_edge) begin
        r_locked  <= 1'b1;
        r_bit_cnt <= 8'd1;
        if (r_locked && (r_bit_cnt != 8'd0) && (r_resync != 8'hFF))
          r_resync <= r_resync + 8'd1;
      end else if (r_locked) begin
        r_bit_cnt <= r_bit_cnt + 8'd1;
      end
      if (w_bit_valid) begin
        if (w_bit_idx == 8'd15) begin
          r_codec_ready <= w_word[15];
          r_tag_ok      <= w_word[15] & w_word[12] & w_word[11];
        end
        if (w_bit_idx == 8'd75) r_left  <= w_word;
        if (w_bit_idx == 8'd95) r_right <= w_word;
      end
    end
  end

  // Write datapath and saturating drop counter
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_din <= 20'd0;
      r_ovf <= '0;
    end else begin
      if ((r_state == IDLE) && w_pending)
        r_din <= r_left;
      else if ((r_state == WR_L) && !fifo_full)
        r_din <= r_right;
      if (w_ovf_inc && !(&r_ovf))
        r_ovf <= r_ovf + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_pending) w_next_state = WR_L;
      // A full FIFO at the left write drops the whole pair.
      WR_L:    w_next_state = fifo_full ? IDLE : WR_R;
      WR_R:    if (!fifo_full) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    fifo_wr_en = 1'b0;
    if ((r_state == WR_L) || (r_state == WR_R))
      fifo_wr_en = ~fifo_full;
  end

  assign fifo_din       = r_din;
  assign locked         = r_locked;
  assign codec_ready    = r_codec_ready;
  assign overflow_count = r_ovf;
  assign resync_count   = r_resync;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_ac97_capture.sv
// Directed bench for ac97_capture: drives whole AC-link frames bit by bit and
// checks FIFO writes (data and accepting edge) plus status counters.
module tb_ac97_capture;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        sdata_in = 1'b0;
  logic        sync = 1'b0;
  logic        capture_en = 1'b1;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [19:0] fifo_din;
  logic        locked;
  logic        codec_ready;
  logic [7:0]  overflow_count;
  logic [7:0]  resync_count;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;
  int last_n = 0;
  int n_a = 0;

  logic [19:0] exp_q[$];
  int          exp_edge_q[$];
  logic [19:0] obs_q[$];
  int          obs_edge_q[$];

  ac97_capture #(.OVF_WIDTH(8)) dut (
    .clk(clk), .rst_b(rst_b), .sdata_in(sdata_in), .sync(sync),
    .capture_en(capture_en), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .locked(locked), .codec_ready(codec_ready),
    .overflow_count(overflow_count), .resync_count(resync_count),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: a write seen mid-cycle is accepted at the next rising edge.
  always @(negedge clk) begin
    if (fifo_wr_en && !fifo_full) begin
      obs_q.push_back(fifo_din);
      obs_edge_q.push_back(edge_cnt + 1);
    end
    if (fifo_wr_en && fifo_full) check_val("wr_en_while_full", 1, 0);
  end

  task automatic expect_write(input logic [19:0] data, input int edge_no);
    exp_q.push_back(data);
    exp_edge_q.push_back(edge_no);
  endtask

  task automatic check_writes(input string tag);
    int n;
    check_val({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_val({tag, "_data"}, obs_q[i], exp_q[i]);
      check_val({tag, "_edge"}, obs_edge_q[i], exp_edge_q[i]);
    end
    obs_q.delete(); obs_edge_q.delete();
    exp_q.delete(); exp_edge_q.delete();
  endtask

  // Driver: bit k of the frame is sampled at edge last_n + k.
  task automatic send_frame(input logic [15:0] tag, input logic [19:0] l, input logic [19:0] r,
                            input int full_lo, input int full_hi, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      @(posedge clk); #2;
      if (k == 0) last_n = edge_cnt + 1;
      sync      = (k < 16);
      fifo_full = (k >= full_lo) && (k <= full_hi);
      if (k < 16)                 sdata_in = tag[15-k];
      else if (k >= 56 && k < 76) sdata_in = l[75-k];
      else if (k >= 76 && k < 96) sdata_in = r[95-k];
      else                        sdata_in = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_b = 1'b0; sync = 1'b0; sdata_in = 1'b0; fifo_full = 1'b0; capture_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_b = 1'b1;
    @(posedge clk);
    obs_q.delete(); obs_edge_q.delete();
  endtask

  initial begin
    // Reset with random line activity
    rst_b = 1'b0;
    repeat (10) begin
      @(posedge clk); #2;
      sync = 1'($urandom_range(0, 1));
      sdata_in = 1'($urandom_range(0, 1));
      capture_en = 1'($urandom_range(0, 1));
      fifo_full = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("reset_outputs",
                {fifo_wr_en, fifo_din, locked, codec_ready, overflow_count, resync_count}, 0);
    end
    // Release with SYNC already high: no false edge
    @(posedge clk); #2;
    rst_b = 1'b1; sync = 1'b1; fifo_full = 1'b0; capture_en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("no_false_sync_locked", locked, 0);
    @(posedge clk); #2 sync = 1'b0;
    obs_q.delete(); obs_edge_q.delete();

    // Nominal frame
    send_frame(16'h9800, 20'hABCDE, 20'h12345, -1, -1, 256);
    expect_write(20'hABCDE, last_n + 96);
    expect_write(20'h12345, last_n + 97);
    check_writes("nominal");
    check_val("nominal_codec_ready", codec_ready, 1);
    check_val("nominal_locked", locked, 1);
    check_val("nominal_ovf", overflow_count, 0);
    check_val("nominal_resync", resync_count, 0);

    // Invalid tags and capture disabled
    send_frame(16'h9000, 20'h11111, 20'h22222, -1, -1, 256);
    check_writes("tag9000");
    check_val("tag9000_codec_ready", codec_ready, 1);
    send_frame(16'h1800, 20'h33333, 20'h44444, -1, -1, 256);
    check_writes("tag1800");
    check_val("tag1800_codec_ready", codec_ready, 0);
    capture_en = 1'b0;
    send_frame(16'h9800, 20'h55555, 20'h66666, -1, -1, 256);
    check_writes("capture_off");
    check_val("capture_off_locked", locked, 1);
    capture_en = 1'b1;

    // Full at left: whole pair dropped, then recovery
    send_frame(16'h9800, 20'h77777, 20'h88888, 96, 96, 256);
    check_writes("full_left");
    check_val("full_left_ovf", overflow_count, 1);
    send_frame(16'h9800, 20'hFEDCB, 20'h0A0A0, -1, -1, 256);
    expect_write(20'hFEDCB, last_n + 96);
    expect_write(20'h0A0A0, last_n + 97);
    check_writes("after_full_left");
    check_val("resync_steady", resync_count, 0);

    // Full at right for 10 edges
    do_reset();
    check_val("reset2_ovf", overflow_count, 0);
    send_frame(16'h9800, 20'h55AA5, 20'h0F0F0, 97, 106, 256);
    expect_write(20'h55AA5, last_n + 96);
    expect_write(20'h0F0F0, last_n + 107);
    check_writes("stall_right");
    check_val("stall_right_ovf", overflow_count, 0);

    // Full held through the next frame's bit 95
    send_frame(16'h9800, 20'h13579, 20'h2468A, 97, 255, 256);
    n_a = last_n;
    send_frame(16'h9800, 20'h33333, 20'h44444, 0, 100, 256);
    expect_write(20'h13579, n_a + 96);
    expect_write(20'h2468A, last_n + 101);
    check_writes("collide");
    check_val("collide_ovf", overflow_count, 1);

    // Resync: SYNC edge at bit 100 of a partial frame
    do_reset();
    send_frame(16'h0000, 20'h00000, 20'h00000, -1, -1, 100);
    check_val("resync_pre", resync_count, 0);
    send_frame(16'h9800, 20'hCAFE1, 20'h0BEEF, -1, -1, 256);
    expect_write(20'hCAFE1, last_n + 96);
    expect_write(20'h0BEEF, last_n + 97);
    check_writes("resync_frame");
    check_val("resync_count", resync_count, 1);
    send_frame(16'h9800, 20'h76543, 20'h89ABC, -1, -1, 256);
    expect_write(20'h76543, last_n + 96);
    expect_write(20'h89ABC, last_n + 97);
    check_writes("resync_next");
    check_val("resync_count_hold", resync_count, 1);

    // Overflow saturation over 300 full frames
    do_reset();
    repeat (300) send_frame(16'h9800, 20'h12121, 20'h34343, 0, 255, 256);
    check_writes("saturate");
    check_val("saturate_ovf", overflow_count, 255);
    @(posedge clk); #2 fifo_full = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
